// File: rtl/key_ram_sched.sv
// Single-port key snapshot RAM scheduler: SPI reads have priority over scan writes,
// a bounded-stall guard force-grants the scan writer, and completed frames are counted.
module key_ram_sched #(
  parameter int GROUPS    = 9,
  parameter int ADDR_W    = 9,
  parameter int STALL_MAX = 4
) (
  input  logic              clk_g_i,
  input  logic              rst_g_i,
  input  logic              scan_valid_i,
  output logic              scan_ready_o,
  input  logic [ADDR_W-1:0] scan_addr_i,
  input  logic [7:0]        scan_data_i,
  input  logic              rd_valid_i,
  output logic              rd_ready_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_data_o,
  output logic              rd_data_valid_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_we_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i,
  output logic              frame_done_o,
  output logic [7:0]        frame_cnt_o
);
  localparam int SW     = $clog2(STALL_MAX + 1);
  localparam int STAGES = 2;
  localparam logic [ADDR_W-1:0] LAST_GRP = ADDR_W'(GROUPS - 1);

  logic [SW-1:0]     stall_cnt;
  logic              force_scan, rd_gnt, scan_gnt;
  logic              scan_in_range, rd_in_range, frame_hit;
  logic [ADDR_W-1:0] last_addr;
  logic [STAGES:1]   vld_pipe;
  logic              oor_q;

  assign scan_in_range = (scan_addr_i <= LAST_GRP);
  assign rd_in_range   = (rd_addr_i <= LAST_GRP);

  // Reads win unless the scan writer has been denied STALL_MAX cycles in a row.
  assign force_scan = scan_valid_i && (stall_cnt == SW'(STALL_MAX));
  assign rd_gnt     = !rst_g_i && rd_valid_i && !force_scan;
  assign scan_gnt   = !rst_g_i && scan_valid_i && !rd_gnt;

  assign rd_ready_o   = rd_gnt;
  assign scan_ready_o = scan_gnt;
  assign frame_hit    = scan_gnt && scan_in_range && (scan_addr_i == LAST_GRP);

  always_comb begin
    ram_addr_o  = last_addr;
    ram_we_o    = 1'b0;
    ram_wdata_o = 8'h00;
    if (scan_gnt) begin
      ram_addr_o = scan_addr_i;
      // Out-of-range writes are accepted but never reach the RAM.
      if (scan_in_range) begin
        ram_we_o    = 1'b1;
        ram_wdata_o = scan_data_i;
      end
    end else if (rd_gnt) begin
      ram_addr_o = rd_addr_i;
    end
  end

  always_ff @(posedge clk_g_i) begin
    if (rst_g_i) begin
      stall_cnt <= '0;
    end else if (!scan_valid_i || scan_gnt) begin
      stall_cnt <= '0;
    end else if (stall_cnt != SW'(STALL_MAX)) begin
      stall_cnt <= stall_cnt + SW'(1);
    end
  end

  always_ff @(posedge clk_g_i) begin
    if (rst_g_i) begin
      last_addr <= '0;
    end else if (scan_gnt) begin
      last_addr <= scan_addr_i;
    end else if (rd_gnt) begin
      last_addr <= rd_addr_i;
    end
  end

  // Stage 1 waits for the synchronous RAM; stage 2 is the registered result.
  always_ff @(posedge clk_g_i) begin
    if (rst_g_i) begin
      vld_pipe  <= '0;
      oor_q     <= 1'b0;
      rd_data_o <= 8'h00;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], rd_gnt};
      oor_q    <= !rd_in_range;
      if (vld_pipe[1]) rd_data_o <= oor_q ? 8'h00 : ram_rdata_i;
    end
  end

  assign rd_data_valid_o = vld_pipe[STAGES];

  always_ff @(posedge clk_g_i) begin
    if (rst_g_i) begin
      frame_done_o <= 1'b0;
      frame_cnt_o  <= 8'h00;
    end else begin
      frame_done_o <= frame_hit;
      if (frame_hit) frame_cnt_o <= frame_cnt_o + 8'h01;
    end
  end
endmodule

// File: tb/tb_key_ram_sched.sv
// Bench for key_ram_sched: RAM model, queue-based reference, directed table and random traffic.
module tb_key_ram_sched;
  localparam int GROUPS = 9, ADDR_W = 9, STALL_MAX = 4;

  logic clk = 1'b0;
  logic rst_g_i = 1'b1;
  logic scan_valid_i = 1'b0, rd_valid_i = 1'b0;
  logic [ADDR_W-1:0] scan_addr_i = '0, rd_addr_i = '0;
  logic [7:0] scan_data_i = '0;
  logic scan_ready_o, rd_ready_o, rd_data_valid_o, ram_we_o, frame_done_o;
  logic [7:0] rd_data_o, ram_wdata_o, frame_cnt_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic [7:0] ram_rdata_i = '0;

  always #5 clk = ~clk;

  key_ram_sched #(.GROUPS(GROUPS), .ADDR_W(ADDR_W), .STALL_MAX(STALL_MAX)) dut (
    .clk_g_i(clk), .rst_g_i(rst_g_i),
    .scan_valid_i(scan_valid_i), .scan_ready_o(scan_ready_o),
    .scan_addr_i(scan_addr_i), .scan_data_i(scan_data_i),
    .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o), .rd_addr_i(rd_addr_i),
    .rd_data_o(rd_data_o), .rd_data_valid_o(rd_data_valid_o),
    .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_wdata_o(ram_wdata_o),
    .ram_rdata_i(ram_rdata_i),
    .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o)
  );

  // Synchronous single-port RAM seen by the DUT.
  logic [7:0] ram [0:511];
  always @(posedge clk) begin
    if (ram_we_o) ram[ram_addr_o] <= ram_wdata_o;
    ram_rdata_i <= ram[ram_addr_o];
  end

  int errors = 0, checks = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model state.
  typedef struct { int due; logic [7:0] data; } rd_exp_t;
  rd_exp_t rq[$];
  logic [7:0] exp_mem [GROUPS];
  int cyc = 0, starve = 0, fcnt = 0;
  bit fd_exp = 0, post_rst = 0, armed = 0, last_sg = 0, last_rg = 0;
  logic [ADDR_W-1:0] last_addr = '0;

  task automatic step(input bit r, input bit sv, input logic [ADDR_W-1:0] sa,
                      input logic [7:0] sd, input bit rv, input logic [ADDR_W-1:0] ra);
    bit fg, rg, sg, ev, ewe;
    @(negedge clk);
    cyc++;
    if (armed) begin
      ev = (rq.size() > 0) && (rq[0].due == cyc);
      chk("rd_data_valid", rd_data_valid_o, ev);
      if (ev) begin
        chk("rd_data", rd_data_o, rq[0].data);
        void'(rq.pop_front());
      end
      chk("frame_done", frame_done_o, fd_exp);
      chk("frame_cnt", frame_cnt_o, fcnt[7:0]);
      if (post_rst) chk("rd_data_after_reset", rd_data_o, 0);
    end
    rst_g_i = r; scan_valid_i = sv; scan_addr_i = sa; scan_data_i = sd;
    rd_valid_i = rv; rd_addr_i = ra;
    #1;
    fg  = sv && (starve == STALL_MAX);
    rg  = !r && rv && !fg;
    sg  = !r && sv && !rg;
    ewe = sg && (sa < GROUPS);
    chk("rd_ready", rd_ready_o, rg);
    chk("scan_ready", scan_ready_o, sg);
    chk("ram_we", ram_we_o, ewe);
    if (ewe) chk("ram_wdata", ram_wdata_o, sd);
    if (!sg && !rg) chk("ram_wdata_idle", ram_wdata_o, 0);
    if (sg) chk("ram_addr_wr", ram_addr_o, sa);
    else if (rg) chk("ram_addr_rd", ram_addr_o, ra);
    else if (armed) chk("ram_addr_hold", ram_addr_o, last_addr);
    if (sg) last_addr = sa;
    else if (rg) last_addr = ra;
    fd_exp = 0;
    if (ewe) begin
      exp_mem[sa] = sd;
      if (sa == GROUPS - 1) begin fd_exp = 1; fcnt = (fcnt + 1) % 256; end
    end
    if (rg) rq.push_back('{cyc + 2, (ra < GROUPS) ? exp_mem[ra] : 8'h00});
    if (!sv || sg) starve = 0;
    else if (starve < STALL_MAX) starve++;
    post_rst = r;
    if (r) begin
      rq.delete(); fcnt = 0; fd_exp = 0; starve = 0; last_addr = '0;
    end
    last_sg = sg; last_rg = rg;
  endtask

  task automatic idle(); step(0, 0, '0, '0, 0, '0); endtask

  typedef struct {
    bit sv; bit rv; logic [ADDR_W-1:0] sa; logic [7:0] sd; logic [ADDR_W-1:0] ra;
    bit e_sr; bit e_rr; bit e_we;
  } vec_t;
  vec_t vt[13];

  initial begin
    bit hs, hr, rr;
    logic [ADDR_W-1:0] sa, ra;
    logic [7:0] sd;

    // Contention table: starting from stall_cnt=0, 4 reads then a forced scan.
    for (int i = 0; i < 10; i++)
      vt[i] = '{1, 1, 9'd5, 8'h3C, 9'd3, (i == 4 || i == 9), !(i == 4 || i == 9), (i == 4 || i == 9)};
    vt[10] = '{1, 0, 9'd12, 8'hFF, 9'd0, 1, 0, 0};
    vt[11] = '{0, 1, 9'd0, 8'h00, 9'd9, 0, 1, 0};
    vt[12] = '{0, 0, 9'd0, 8'h00, 9'd0, 0, 0, 0};

    step(1, 0, '0, '0, 0, '0);
    armed = 1;
    step(1, 1, 9'd2, 8'h11, 1, 9'd2);
    idle();
    chk("reset_frame_cnt", frame_cnt_o, 0);
    chk("reset_rd_valid", rd_data_valid_o, 0);

    // Single write then read of group 3.
    step(0, 1, 9'd3, 8'hA5, 0, '0);
    idle();
    step(0, 0, '0, '0, 1, 9'd3);
    idle();
    chk("wr_rd_valid_n1", rd_data_valid_o, 0);
    idle();
    chk("wr_rd_valid_n2", rd_data_valid_o, 1);
    chk("wr_rd_data", rd_data_o, 8'hA5);

    // One full frame, then 255 more to wrap the counter.
    for (int g = 0; g < GROUPS; g++) step(0, 1, 9'(g), 8'(8'h10 + g), 0, '0);
    idle();
    chk("frame_done_pulse", frame_done_o, 1);
    chk("frame_cnt_one", frame_cnt_o, 1);
    idle();
    chk("frame_done_clear", frame_done_o, 0);
    for (int f = 1; f < 256; f++)
      for (int g = 0; g < GROUPS; g++) step(0, 1, 9'(g), 8'(8'h10 + g), 0, '0);
    idle();
    chk("frame_cnt_wrap", frame_cnt_o, 0);

    // Pipelined reads of groups 0,1,2.
    step(0, 0, '0, '0, 1, 9'd0);
    step(0, 0, '0, '0, 1, 9'd1);
    step(0, 0, '0, '0, 1, 9'd2);
    chk("pipe_v0", rd_data_valid_o, 1); chk("pipe_d0", rd_data_o, 8'h10);
    idle();
    chk("pipe_v1", rd_data_valid_o, 1); chk("pipe_d1", rd_data_o, 8'h11);
    idle();
    chk("pipe_v2", rd_data_valid_o, 1); chk("pipe_d2", rd_data_o, 8'h12);
    idle();
    chk("pipe_end", rd_data_valid_o, 0);

    // Out-of-range read and write.
    step(0, 0, '0, '0, 1, 9'd9);
    idle();
    idle();
    chk("oor_rd_valid", rd_data_valid_o, 1);
    chk("oor_rd_data", rd_data_o, 8'h00);
    step(0, 1, 9'd12, 8'hFF, 0, '0);
    chk("oor_wr_ready", scan_ready_o, 1);
    chk("oor_wr_we", ram_we_o, 0);
    idle();
    chk("oor_wr_no_frame", frame_done_o, 0);

    // Table-driven grant vectors.
    idle();
    foreach (vt[i]) begin
      step(0, vt[i].sv, vt[i].sa, vt[i].sd, vt[i].rv, vt[i].ra);
      chk($sformatf("tbl%0d_scan_ready", i), scan_ready_o, vt[i].e_sr);
      chk($sformatf("tbl%0d_rd_ready", i), rd_ready_o, vt[i].e_rr);
      chk($sformatf("tbl%0d_we", i), ram_we_o, vt[i].e_we);
    end
    idle(); idle(); idle();

    // Reset the cycle after a read grant: the read must vanish.
    step(0, 0, '0, '0, 1, 9'd3);
    step(1, 0, '0, '0, 1, 9'd3);
    chk("rst_mid_rd_ready", rd_ready_o, 0);
    idle();
    chk("rst_mid_valid_n2", rd_data_valid_o, 0);
    chk("rst_mid_data", rd_data_o, 8'h00);
    chk("rst_mid_frame_cnt", frame_cnt_o, 0);
    chk("rst_mid_frame_done", frame_done_o, 0);
    idle();
    chk("rst_mid_valid_n3", rd_data_valid_o, 0);

    // Random traffic; requesters hold addr/data until granted.
    hs = 0; hr = 0; sa = '0; ra = '0; sd = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!hs && $urandom_range(0, 3) != 0) begin
        hs = 1; sa = 9'($urandom_range(0, 11)); sd = 8'($urandom);
      end
      if (!hr && $urandom_range(0, 3) != 0) begin
        hr = 1; ra = 9'($urandom_range(0, 11));
      end
      rr = ($urandom_range(0, 199) == 0);
      step(rr, hs, sa, sd, hr, ra);
      if (last_sg) hs = 0;
      if (last_rg) hr = 0;
    end
    idle(); idle(); idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/key_ram_sched.md
Name: key_ram_sched

Overview:
Scheduler for the single-port key snapshot RAM (8-bit words, one word per 8-key group).
- Arbitrates between two requesters: the scan writer, which pushes debounced key groups, and the SPI read path, which fetches groups for MISO.
- Grants one RAM operation per cycle, with SPI reads taking priority. A bounded-stall guard keeps the scan writer from starving.
- Tracks completed scan frames so firmware can detect a fresh snapshot.

Parameters:
GROUPS, 9, number of valid group addresses (0..GROUPS-1)
ADDR_W, 9, RAM address width (512-deep RAM)
STALL_MAX, 4, consecutive denied scan cycles before scan is force-granted (>=1)

Ports:
clk_g_i  in  1  system clock (12 MHz)
rst_g_i  in  1  synchronous, active-high reset
scan_valid_i  in  1  scan writer has a group to write
scan_ready_o  out  1  scan write granted this cycle
scan_addr_i  in  ADDR_W  group index to write
scan_data_i  in  8  group key bits
rd_valid_i  in  1  SPI path requests a group read
rd_ready_o  out  1  read granted this cycle
rd_addr_i  in  ADDR_W  group index to read
rd_data_o  out  8  read data
rd_data_valid_o  out  1  rd_data_o valid (one-cycle pulse per granted read)
ram_addr_o  out  ADDR_W  RAM address
ram_we_o  out  1  RAM write enable
ram_wdata_o  out  8  RAM write data
ram_rdata_i  in  8  RAM read data, synchronous (valid the cycle after address)
frame_done_o  out  1  one-cycle pulse after write to group GROUPS-1
frame_cnt_o  out  8  completed frame count, wraps 255->0

Behaviour:
- One clock, clk_g_i; reset is synchronous, active-high on rst_g_i. All state is updated on the rising edge.
- Reset values: rd_data_o=0, rd_data_valid_o=0, frame_done_o=0, frame_cnt_o=0, stall_cnt=0, read-pipeline valid bits=0.
- While rst_g_i=1: scan_ready_o=0, rd_ready_o=0, ram_we_o=0.
- Handshake: a transfer occurs in any cycle where valid and ready are both 1. Ready is combinational from the valids and stall_cnt. Requesters hold addr/data stable until granted.
- Grant rule, evaluated each cycle:
  - force = scan_valid_i && (stall_cnt == STALL_MAX).
  - Read grant = rd_valid_i && !force.
  - Scan grant = scan_valid_i && !read grant.
  - At most one grant per cycle.
- stall_cnt (width clog2(STALL_MAX+1)):
  - Cleared on a scan grant, or when scan_valid_i=0.
  - Incremented when scan_valid_i=1 and scan is denied.
  - Saturates at STALL_MAX.
- RAM port (combinational from the grant):
  - Write grant: ram_addr_o=scan_addr_i, ram_we_o=1, ram_wdata_o=scan_data_i.
  - Read grant: ram_addr_o=rd_addr_i, ram_we_o=0.
  - Idle: ram_addr_o holds its last value, ram_we_o=0, ram_wdata_o=0.
- Read latency is fixed at 2 cycles:
  - Read granted in cycle N; ram_rdata_i is valid in N+1; rd_data_o is registered and presented with rd_data_valid_o=1 in N+2.
  - Back-to-back reads are pipelined, one result per cycle.
- Out-of-range addresses (addr >= GROUPS):
  - Read: still granted and follows the same 2-cycle timing, but rd_data_o=8'h00 and the RAM data is ignored.
  - Write: granted (ready=1), but ram_we_o=0 and the data is dropped; it does not count toward frame_done.
- Read-after-write: a write to addr A in cycle N followed by a read of A in cycle N+1 returns the new data. The RAM is write-first across cycles; no bypass logic is needed.
- Frame tracking: a granted in-range write to GROUPS-1 in cycle N gives frame_done_o=1 in N+1 and frame_cnt_o incremented in N+1, wrapping modulo 256.
- Reset mid-operation: in-flight read pipeline entries are discarded, so no rd_data_valid_o follows reset. stall_cnt and frame_cnt_o clear.
- Simultaneous valids with stall_cnt < STALL_MAX: read wins. With stall_cnt == STALL_MAX: scan wins, rd_ready_o=0, and the read retries next cycle.

Test Plan:
- Single write then read: write addr 3 = 8'hA5; after idle, read addr 3 -> rd_data_valid_o and rd_data_o=8'hA5 exactly 2 cycles after the read grant.
- Contention/starvation: rd_valid_i and scan_valid_i held high continuously, STALL_MAX=4 -> pattern of 4 read grants, 1 scan grant, repeating; stall_cnt returns to 0 after each scan grant.
- Frame: write groups 0..8 back-to-back with no reads -> frame_done_o pulses once, cycle after the addr-8 write; frame_cnt_o 0->1; 256 frames -> frame_cnt_o wraps to 0.
- Out of range: read addr 9 -> rd_data_o=8'h00 with valid at +2; write addr 12 = 8'hFF -> ram_we_o stays 0, scan_ready_o=1, no frame_done.
- Pipelined reads: reads of addr 0,1,2 granted in consecutive cycles -> three consecutive rd_data_valid_o cycles with data in order.
- Reset mid-read: assert rst_g_i the cycle after a read grant -> no rd_data_valid_o; all outputs at reset values the cycle after reset.
